uart_cmd_parse: RTL
===================

// Module: uart_cmd_parse
// PURPOSE
//  ASCII command parser downstream of uart_rx (consumes rx_data/rx_data_rdy).
//  Decodes "*<cmd><hex args><CR>" frames and updates control registers for later
//  stages (LED value, speed word). Emits one response byte per frame
//  ('K' = ok, 'E' = error) on a valid/ready port for a UART transmitter.
// PARAMETERS
//  CLOCK_RATE   125_000_000  clk_rx frequency in Hz (informational; documents TIMEOUT_CYC)
//  TIMEOUT_CYC  12_500_000   max idle cycles between bytes inside a frame (100 ms)
//  SPD_DEFAULT  16'h0100     reset value of spd_val
// PORTS
//  clk_rx       in   1   system clock
//  rst_clk_rx   in   1   synchronous reset, active high
//  rx_data      in   8   received byte, valid when rx_data_rdy=1
//  rx_data_rdy  in   1   single-cycle strobe from uart_rx
//  led_val      out  8   LED register
//  led_upd      out  1   1-cycle pulse when led_val is written
//  spd_val      out  16  speed register
//  spd_upd      out  1   1-cycle pulse when spd_val is written
//  rsp_data     out  8   response byte: 8'h4B 'K' or 8'h45 'E'
//  rsp_valid    out  1   response pending; held until rsp_ready
//  rsp_ready    in   1   consumer accepts rsp_data when rsp_valid & rsp_ready
// BEHAVIOUR
//  Reset: state IDLE; led_val=0, spd_val=SPD_DEFAULT; led_upd=spd_upd=0;
//   rsp_valid=0, rsp_data=0; arg shift reg, digit count, timeout counter cleared.
//   Reset mid-frame discards the frame; no response is produced.
//  Commands: 'L'+2 hex -> led_val; 'S'+4 hex -> spd_val; 'C'+0 hex -> led_val=0,
//   spd_val=SPD_DEFAULT (both upd pulses). Command letter is case-sensitive upper.
//  Hex digits: 0-9, A-F, a-f. Each digit: arg = {arg[11:0], nib}; 'L' uses arg[7:0].
//  FSM (advances only on rx_data_rdy, except timeout/handshake):
//   IDLE: '*' -> CMD; all other bytes ignored, no response.
//   CMD:  'L'/'S' -> ARG (count=2/4, arg=0); 'C' -> EOL; other -> RESP('E').
//   ARG:  hex -> shift, count-1; count reaches 0 -> EOL; non-hex -> RESP('E').
//   EOL:  8'h0D -> commit registers, RESP('K'); other -> RESP('E').
//   RESP: rsp_valid=1; on rsp_valid&rsp_ready -> IDLE, rsp_valid=0 next cycle.
//  '*' received in CMD/ARG/EOL restarts at CMD (resync, no response for the
//   abandoned frame).
//  Latency: CR strobe at cycle N -> register value, upd pulse and rsp_valid all
//   visible at N+1. Error byte at cycle N -> rsp_valid at N+1.
//  Timeout: counter clears on every rx_data_rdy and in IDLE/RESP; in CMD/ARG/EOL
//   reaching TIMEOUT_CYC-1 -> RESP('E'). Byte strobe in the expiry cycle wins
//   (byte processed, counter cleared, no timeout).
//  Bytes arriving while in RESP (including the cycle of the handshake) are
//   dropped; parser returns to IDLE and needs a fresh '*'.
//  rsp_data stable while rsp_valid=1. No register write on any error path.
// STRUCTURE
//  Package uart_cmd_pkg: ASCII constants (STAR, CR, 'K','E','L','S','C'),
//   state encoding localparams, per-command arg counts.
//  Sub-module hex_to_nib: combinational ASCII -> {is_hex, nib[3:0]} decoder.
//  Timeout counter width = $clog2(TIMEOUT_CYC); bench overrides TIMEOUT_CYC=64.
// TESTING
//  T1 "*L5A\r", rsp_ready=1 -> led_val=8'h5A, one led_upd pulse, one 'K', spd_val unchanged.
//  T2 "*S12ab\r" -> spd_val=16'h12AB, one spd_upd, 'K'; then "*C\r" -> led_val=0,
//     spd_val=16'h0100, both upd pulses, 'K'.
//  T3 "*LG1\r" -> 'E' right after 'G'; "1\r" ignored; led_val unchanged;
//     "*X" -> 'E'; "*L12Z" -> 'E'.
//  T4 "*L1" then 64 idle cycles (TIMEOUT_CYC=64) -> 'E'; byte on 64th cycle
//     -> no 'E', frame completes with "2\r" -> led_val=8'h12.
//  T5 rsp_ready=0 for 20 cycles after "*L33\r" -> rsp_valid/rsp_data='K' held;
//     "*L44\r" sent meanwhile is dropped; led_val stays 8'h33.
//  T6 "*S12" then rst_clk_rx 1 cycle -> all outputs at reset values, no response;
//     "*L*L77\r" -> resync, single 'K', led_val=8'h77.

Source files
------------

// File: rtl/uart_cmd_parse_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_cmd_pkg
//  Brief   : Shared constants for the ASCII command parser: frame characters,
//            response codes, command letters, state encoding and the number
//            of hex digits each command carries.
//  Revision: 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

    // Frame delimiters
    localparam logic [7:0] C_STAR = 8'h2A;   // '*' start of frame
    localparam logic [7:0] C_CR   = 8'h0D;   // carriage return, end of frame

    // Response codes
    localparam logic [7:0] C_RSP_OK  = 8'h4B; // 'K'
    localparam logic [7:0] C_RSP_ERR = 8'h45; // 'E'

    // Command letters (upper case only)
    localparam logic [7:0] C_CMD_LED   = 8'h4C; // 'L'
    localparam logic [7:0] C_CMD_SPD   = 8'h53; // 'S'
    localparam logic [7:0] C_CMD_CLEAR = 8'h43; // 'C'

    // Hex digits expected after each command letter
    localparam logic [2:0] C_ARGS_LED = 3'd2;
    localparam logic [2:0] C_ARGS_SPD = 3'd4;

    // Parser state encoding
    localparam int unsigned C_ST_W = 3;
    localparam logic [C_ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [C_ST_W-1:0] ST_CMD  = 3'd1;
    localparam logic [C_ST_W-1:0] ST_ARG  = 3'd2;
    localparam logic [C_ST_W-1:0] ST_EOL  = 3'd3;
    localparam logic [C_ST_W-1:0] ST_RESP = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parse_hex_to_nib.sv
`default_nettype none
// ============================================================================
//  Module  : hex_to_nib
//  Brief   : Combinational ASCII to nibble decoder. Accepts 0-9, A-F, a-f;
//            o_is_hex flags whether the byte was a hex digit at all.
//  Revision: 1.0  initial release
// ============================================================================
module hex_to_nib (
    input  logic [7:0] i_ascii,
    output logic       o_is_hex,
    output logic [3:0] o_nib
);

    // Letters map as low nibble + 9 ('A'/'a' = x1 -> 10 ... 'F'/'f' = x6 -> 15)
    always_comb begin
        o_is_hex = 1'b1;
        o_nib    = 4'h0;
        if (i_ascii >= 8'h30 && i_ascii <= 8'h39) begin
            o_nib = i_ascii[3:0];
        end else if ((i_ascii >= 8'h41 && i_ascii <= 8'h46) ||
                     (i_ascii >= 8'h61 && i_ascii <= 8'h66)) begin
            o_nib = i_ascii[3:0] + 4'd9;
        end else begin
            o_is_hex = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parse.sv
`default_nettype none
// ============================================================================
//  Module  : uart_cmd_parse
//  Brief   : Parses "*<cmd><hex args><CR>" frames from a UART receiver,
//            updates the LED and speed control registers and returns one
//            'K'/'E' response byte per frame over a valid/ready port.
//  Revision: 1.0  initial release
// ============================================================================
module uart_cmd_parse
    import uart_cmd_pkg::*;
#(
    parameter int          CLOCK_RATE  = 125_000_000,
    parameter int          TIMEOUT_CYC = 12_500_000,
    parameter logic [15:0] SPD_DEFAULT = 16'h0100
) (
    input  logic        clk_rx,
    input  logic        rst_clk_rx,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_rdy,
    output logic [7:0]  led_val,
    output logic        led_upd,
    output logic [15:0] spd_val,
    output logic        spd_upd,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready
);

    localparam int unsigned   C_TMO_W   = $clog2(TIMEOUT_CYC);
    localparam logic [C_TMO_W-1:0] C_TMO_MAX = C_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [C_TMO_W-1:0] C_TMO_ONE = C_TMO_W'(1);

    // The timeout counter needs at least one bit, and CLOCK_RATE only documents
    // how TIMEOUT_CYC was chosen; an empty block keeps both parameters bound.
    if (TIMEOUT_CYC < 2 || CLOCK_RATE < 1) begin : g_param_check
    end

    logic [C_ST_W-1:0]  r_state, w_state_nxt;
    logic [15:0]        r_arg, w_arg_nxt;
    logic [2:0]         r_cnt, w_cnt_nxt;
    logic [7:0]         r_cmd, w_cmd_nxt;
    logic [C_TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic [7:0]         r_led, w_led_nxt;
    logic [15:0]        r_spd, w_spd_nxt;
    logic               r_led_upd, w_led_upd_nxt;
    logic               r_spd_upd, w_spd_upd_nxt;
    logic [7:0]         r_rsp_data, w_rsp_data_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;

    logic               w_is_hex;
    logic [3:0]         w_nib;

    hex_to_nib u_hex_to_nib (
        .i_ascii  (rx_data),
        .o_is_hex (w_is_hex),
        .o_nib    (w_nib)
    );

    // State and register file update
    always_ff @(posedge clk_rx) begin
        if (rst_clk_rx) begin
            r_state     <= ST_IDLE;
            r_arg       <= '0;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_tmo       <= '0;
            r_led       <= '0;
            r_spd       <= SPD_DEFAULT;
            r_led_upd   <= 1'b0;
            r_spd_upd   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_arg       <= w_arg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_tmo       <= w_tmo_nxt;
            r_led       <= w_led_nxt;
            r_spd       <= w_spd_nxt;
            r_led_upd   <= w_led_upd_nxt;
            r_spd_upd   <= w_spd_upd_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    // Next-state decode: bytes drive the frame FSM, idle time drives the timeout
    always_comb begin
        w_state_nxt     = r_state;
        w_arg_nxt       = r_arg;
        w_cnt_nxt       = r_cnt;
        w_cmd_nxt       = r_cmd;
        w_tmo_nxt       = '0;
        w_led_nxt       = r_led;
        w_spd_nxt       = r_spd;
        w_led_upd_nxt   = 1'b0;
        w_spd_upd_nxt   = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_valid_nxt = r_rsp_valid;

        case (r_state)
            ST_IDLE: begin
                if (rx_data_rdy && rx_data == C_STAR) begin
                    w_state_nxt = ST_CMD;
                end
            end

            ST_CMD, ST_ARG, ST_EOL: begin
                if (rx_data_rdy) begin
                    if (rx_data == C_STAR) begin
                        // Resync: abandon the current frame silently
                        w_state_nxt = ST_CMD;
                    end else begin
                        // Error is the fallback; valid bytes override below
                        w_state_nxt     = ST_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = C_RSP_ERR;
                        case (r_state)
                            ST_CMD: begin
                                if (rx_data == C_CMD_LED || rx_data == C_CMD_SPD) begin
                                    w_state_nxt     = ST_ARG;
                                    w_rsp_valid_nxt = 1'b0;
                                    w_rsp_data_nxt  = r_rsp_data;
                                    w_cmd_nxt       = rx_data;
                                    w_arg_nxt       = '0;
                                    w_cnt_nxt       = (rx_data == C_CMD_LED) ? C_ARGS_LED
                                                                             : C_ARGS_SPD;
                                end else if (rx_data == C_CMD_CLEAR) begin
                                    w_state_nxt     = ST_EOL;
                                    w_rsp_valid_nxt = 1'b0;
                                    w_rsp_data_nxt  = r_rsp_data;
                                    w_cmd_nxt       = rx_data;
                                end
                            end
                            ST_ARG: begin
                                if (w_is_hex) begin
                                    w_rsp_valid_nxt = 1'b0;
                                    w_rsp_data_nxt  = r_rsp_data;
                                    w_arg_nxt       = {r_arg[11:0], w_nib};
                                    w_cnt_nxt       = r_cnt - 3'd1;
                                    w_state_nxt     = (r_cnt == 3'd1) ? ST_EOL : ST_ARG;
                                end
                            end
                            default: begin // ST_EOL
                                if (rx_data == C_CR) begin
                                    w_rsp_data_nxt = C_RSP_OK;
                                    if (r_cmd == C_CMD_LED) begin
                                        w_led_nxt     = r_arg[7:0];
                                        w_led_upd_nxt = 1'b1;
                                    end else if (r_cmd == C_CMD_SPD) begin
                                        w_spd_nxt     = r_arg;
                                        w_spd_upd_nxt = 1'b1;
                                    end else begin
                                        w_led_nxt     = '0;
                                        w_spd_nxt     = SPD_DEFAULT;
                                        w_led_upd_nxt = 1'b1;
                                        w_spd_upd_nxt = 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end else if (r_tmo == C_TMO_MAX) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = C_RSP_ERR;
                end else begin
                    w_tmo_nxt = r_tmo + C_TMO_ONE;
                end
            end

            ST_RESP: begin
                // Incoming bytes are dropped here; only the handshake matters
                if (rsp_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    assign led_val   = r_led;
    assign led_upd   = r_led_upd;
    assign spd_val   = r_spd;
    assign spd_upd   = r_spd_upd;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;

endmodule
`default_nettype wire
